// File: rtl/stdp_update_scheduler.sv
// stdp_update_scheduler: turns pre/post spike pairings into round-robin STDP update requests.
// Define STDP_SCHED_STATS_EN to build the saturating issued-LTP/LTD counters.
module stdp_update_scheduler #(
    parameter int N_PRE  = 5,
    parameter int TW     = 8,
    parameter int WINDOW = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [N_PRE-1:0] pre_spike,
    input  logic             post_spike,
    output logic             upd_valid,
    input  logic             upd_ready,
    output logic [2:0]       upd_chan,
    output logic             upd_ltp,
    output logic [TW-1:0]    upd_dt,
    output logic             busy,
    output logic             overflow,
    output logic [7:0]       stat_ltp,
    output logic [7:0]       stat_ltd
);
    localparam logic [TW-1:0]    WIN = TW'(WINDOW);
    localparam logic [TW-1:0]    MAX = '1;
    localparam logic [N_PRE-1:0] ONE = 1;

    typedef enum logic {IDLE, OFFER} state_t;
    state_t state_q, state_d;

    logic [TW-1:0]    pre_t_q [N_PRE];
    logic [TW-1:0]    post_t_q;
    logic [TW-1:0]    dt_ltp_q [N_PRE];
    logic [TW-1:0]    dt_ltd_q [N_PRE];
    logic [N_PRE-1:0] ltp_pend_q, ltd_pend_q, ltp_cap, ltd_cap, iss_ltp, iss_ltd;
    logic [2:0]       rr_q, upd_chan_q, sel_chan, j;
    logic             upd_ltp_q, overflow_q, sel_found, sel_ltp, hs, any_pend;
    logic [TW-1:0]    upd_dt_q, sel_dt;

    assign hs        = (state_q == OFFER) && upd_ready;
    assign any_pend  = |{ltp_pend_q, ltd_pend_q};
    assign upd_valid = (state_q == OFFER);
    assign upd_chan  = upd_chan_q;
    assign upd_ltp   = upd_ltp_q;
    assign upd_dt    = upd_dt_q;
    assign overflow  = overflow_q;
    assign busy      = any_pend || upd_valid;
    assign iss_ltp   = (hs && upd_ltp_q) ? ONE << upd_chan_q : '0;
    assign iss_ltd   = (hs && !upd_ltp_q) ? ONE << upd_chan_q : '0;

    always_comb begin
        ltp_cap = '0;
        ltd_cap = '0;
        for (int i = 0; i < N_PRE; i++) begin
            ltp_cap[i] = ena && post_spike && (pre_spike[i] || pre_t_q[i] <= WIN);
            ltd_cap[i] = ena && pre_spike[i] && !post_spike && (post_t_q <= WIN);
        end
    end

    // First channel at or after rr_q (with wrap) that has anything pending.
    always_comb begin
        sel_found = 1'b0;
        sel_chan  = '0;
        j         = '0;
        for (int k = 0; k < N_PRE; k++) begin
            j = 3'((32'(rr_q) + k) % N_PRE);
            if (!sel_found && (ltp_pend_q[j] || ltd_pend_q[j])) begin
                sel_found = 1'b1;
                sel_chan  = j;
            end
        end
        sel_ltp = !ltd_pend_q[sel_chan];
        sel_dt  = sel_ltp ? dt_ltp_q[sel_chan] : dt_ltd_q[sel_chan];
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) state_d = any_pend ? OFFER : IDLE;
        else                 state_d = upd_ready ? IDLE : OFFER;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            post_t_q   <= MAX;
            ltp_pend_q <= '0;
            ltd_pend_q <= '0;
            rr_q       <= '0;
            upd_chan_q <= '0;
            upd_ltp_q  <= 1'b0;
            upd_dt_q   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < N_PRE; i++) begin
                pre_t_q[i]  <= MAX;
                dt_ltp_q[i] <= '0;
                dt_ltd_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (ena) begin
                post_t_q <= post_spike ? '0 : (post_t_q == MAX) ? MAX : post_t_q + 1'b1;
                for (int i = 0; i < N_PRE; i++)
                    pre_t_q[i] <= pre_spike[i] ? '0 : (pre_t_q[i] == MAX) ? MAX : pre_t_q[i] + 1'b1;
            end
            // A capture landing on the bit being issued wins and stays pending.
            ltp_pend_q <= (ltp_pend_q & ~iss_ltp) | ltp_cap;
            ltd_pend_q <= (ltd_pend_q & ~iss_ltd) | ltd_cap;
            for (int i = 0; i < N_PRE; i++) begin
                if (ltp_cap[i]) dt_ltp_q[i] <= pre_spike[i] ? '0 : pre_t_q[i];
                if (ltd_cap[i]) dt_ltd_q[i] <= post_t_q;
            end
            overflow_q <= overflow_q || |((ltp_cap & ltp_pend_q & ~iss_ltp) | (ltd_cap & ltd_pend_q & ~iss_ltd));
            if (state_q == IDLE && sel_found) begin
                upd_chan_q <= sel_chan;
                upd_ltp_q  <= sel_ltp;
                upd_dt_q   <= sel_dt;
            end
            if (hs) rr_q <= (upd_chan_q == 3'(N_PRE - 1)) ? '0 : upd_chan_q + 3'd1;
        end
    end

`ifdef STDP_SCHED_STATS_EN
    logic [7:0] stat_ltp_q, stat_ltd_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ltp_q <= '0;
            stat_ltd_q <= '0;
        end else if (hs) begin
            if (upd_ltp_q && stat_ltp_q != 8'hff)  stat_ltp_q <= stat_ltp_q + 8'd1;
            if (!upd_ltp_q && stat_ltd_q != 8'hff) stat_ltd_q <= stat_ltd_q + 8'd1;
        end
    end
    assign stat_ltp = stat_ltp_q;
    assign stat_ltd = stat_ltd_q;
`else
    assign stat_ltp = '0;
    assign stat_ltd = '0;
`endif
endmodule

// File: tb/tb_stdp_update_scheduler.sv
// tb_stdp_update_scheduler: directed and random stimulus against a timestamp-based reference model.
module tb_stdp_update_scheduler;
    localparam int N = 5;
    localparam int TW = 8;
    localparam int W = 64;

    logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0, post_spike = 1'b0, upd_ready = 1'b0;
    logic [N-1:0] pre_spike = '0;
    logic upd_valid, upd_ltp, busy, overflow;
    logic [2:0] upd_chan;
    logic [TW-1:0] upd_dt;
    logic [7:0] stat_ltp, stat_ltd;

    stdp_update_scheduler #(.N_PRE(N), .TW(TW), .WINDOW(W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pre_spike(pre_spike), .post_spike(post_spike),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_chan(upd_chan), .upd_ltp(upd_ltp),
        .upd_dt(upd_dt), .busy(busy), .overflow(overflow), .stat_ltp(stat_ltp), .stat_ltd(stat_ltd)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
    endtask

    // Model: ages are differences of enabled-cycle timestamps, saturated at 2^TW-1.
    int ecnt, post_stamp, rr, m_chan, m_dt, stl, std_;
    int pre_stamp[N], ldt[N], ddt[N];
    bit lp[N], dp[N];
    bit m_valid, m_ltp, m_ovf;

    function automatic int age(input int s);
        return (ecnt - s > 255) ? 255 : ecnt - s;
    endfunction

    task automatic model_reset();
        ecnt = 0; post_stamp = -1000; rr = 0; m_chan = 0; m_dt = 0; stl = 0; std_ = 0;
        m_valid = 0; m_ltp = 0; m_ovf = 0;
        for (int i = 0; i < N; i++) begin
            pre_stamp[i] = -1000; lp[i] = 0; dp[i] = 0; ldt[i] = 0; ddt[i] = 0;
        end
    endtask

    task automatic model_step(input logic [N-1:0] p, input logic po, input logic e, input logic r);
        bit cl[N], cd[N];
        int dl[N];
        int pa, c;
        bit any, hs, found;
        hs = m_valid && r;
        any = 0;
        for (int i = 0; i < N; i++) any |= lp[i] | dp[i];
        pa = age(post_stamp);
        for (int i = 0; i < N; i++) begin
            cl[i] = e && po && (p[i] || age(pre_stamp[i]) <= W);
            dl[i] = p[i] ? 0 : age(pre_stamp[i]);
            cd[i] = e && p[i] && !po && pa <= W;
        end
        if (hs) begin
            if (m_ltp) begin lp[m_chan] = 0; stl = (stl < 255) ? stl + 1 : 255; end
            else begin dp[m_chan] = 0; std_ = (std_ < 255) ? std_ + 1 : 255; end
            rr = (m_chan + 1) % N;
            m_valid = 0;
        end else if (!m_valid && any) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                c = (rr + k) % N;
                if (!found && (lp[c] || dp[c])) begin
                    found = 1; m_chan = c; m_ltp = !dp[c]; m_dt = dp[c] ? ddt[c] : ldt[c];
                end
            end
            m_valid = 1;
        end
        for (int i = 0; i < N; i++) begin
            if (cl[i]) begin m_ovf |= lp[i]; lp[i] = 1; ldt[i] = dl[i]; end
            if (cd[i]) begin m_ovf |= dp[i]; dp[i] = 1; ddt[i] = pa; end
        end
        if (e) begin
            ecnt++;
            for (int i = 0; i < N; i++) if (p[i]) pre_stamp[i] = ecnt;
            if (po) post_stamp = ecnt;
        end
    endtask

    task automatic compare_all();
        bit mbusy;
        mbusy = m_valid;
        for (int i = 0; i < N; i++) mbusy |= lp[i] | dp[i];
        check("valid", upd_valid, m_valid);
        check("busy", busy, mbusy);
        check("overflow", overflow, m_ovf);
        if (m_valid) begin
            check("chan", upd_chan, m_chan);
            check("ltp", upd_ltp, m_ltp);
            check("dt", upd_dt, m_dt);
        end
`ifdef STDP_SCHED_STATS_EN
        check("stat_ltp", stat_ltp, stl);
        check("stat_ltd", stat_ltd, std_);
`else
        check("stat_ltp", stat_ltp, 0);
        check("stat_ltd", stat_ltd, 0);
`endif
    endtask

    // Called at a negedge: drive, let the edge happen, then compare at the next negedge.
    task automatic cycle(input logic [N-1:0] p, input logic po, input logic e, input logic r);
        pre_spike = p; post_spike = po; ena = e; upd_ready = r;
        @(posedge clk);
        model_step(p, po, e, r);
        @(negedge clk);
        pre_spike = '0; post_spike = 1'b0;
        compare_all();
    endtask

    task automatic idle(input int n, input logic r);
        repeat (n) cycle('0, 1'b0, 1'b1, r);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_valid", upd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        check("rst_chan", upd_chan, 0);
        check("rst_dt", upd_dt, 0);
        check("rst_stat", stat_ltp + stat_ltd, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int exp_ch[3] = '{0, 1, 3};
    int c0, d0, w;

    initial begin
        @(negedge clk);
        do_reset();

        cycle('0, 1'b1, 1'b1, 1'b1);
        idle(2, 1'b1);
        check("lone_post_valid", upd_valid, 0);
        check("lone_post_busy", busy, 0);

        cycle(5'b00100, 1'b0, 1'b1, 1'b1);
        idle(10, 1'b1);
        cycle('0, 1'b1, 1'b1, 1'b1);
        check("ltp_lat1", upd_valid, 0);
        idle(1, 1'b1);
        check("ltp_lat2", upd_valid, 1);
        check("ltp_chan", upd_chan, 2);
        check("ltp_dir", upd_ltp, 1);
        check("ltp_dt", upd_dt, 10);
        idle(80, 1'b1);

        cycle('0, 1'b1, 1'b1, 1'b1);
        idle(5, 1'b1);
        cycle(5'b10000, 1'b0, 1'b1, 1'b1);
        idle(1, 1'b1);
        check("ltd_chan", upd_chan, 4);
        check("ltd_dir", upd_ltp, 0);
        check("ltd_dt", upd_dt, 5);
        idle(80, 1'b1);
        cycle('0, 1'b1, 1'b1, 1'b1);
        idle(70, 1'b1);
        cycle(5'b10000, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b1);
        check("outside_win", busy, 0);
        idle(80, 1'b1);

        cycle(5'b01011, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b0);
        cycle('0, 1'b1, 1'b1, 1'b0);
        idle(1, 1'b0);
        c0 = upd_chan; d0 = upd_dt;
        repeat (20) begin
            idle(1, 1'b0);
            check("stall_valid", upd_valid, 1);
            check("stall_chan", upd_chan, c0);
            check("stall_dt", upd_dt, d0);
        end
        for (int k = 0; k < 3; k++) begin
            w = 0;
            while (!upd_valid && w < 10) begin idle(1, 1'b1); w++; end
            check("rr_wait", int'(w < 10), 1);
            check("rr_chan", upd_chan, exp_ch[k]);
            check("rr_dt", upd_dt, 3);
            idle(1, 1'b1);
        end
        idle(80, 1'b1);

        cycle(5'b00010, 1'b1, 1'b1, 1'b0);
        idle(1, 1'b0);
        check("sim_chan", upd_chan, 1);
        check("sim_dir", upd_ltp, 1);
        check("sim_dt", upd_dt, 0);
        idle(1, 1'b0);
        cycle('0, 1'b1, 1'b1, 1'b0);
        check("ovf_set", overflow, 1);
        check("ovf_payload_dt", upd_dt, 0);
        idle(10, 1'b1);
        check("no_ltd", busy, 0);

        repeat (300) begin
            cycle(5'b00001, 1'b1, 1'b1, 1'b1);
            idle(2, 1'b1);
        end
`ifdef STDP_SCHED_STATS_EN
        check("stat_ltp_sat", stat_ltp, 255);
`else
        check("stat_ltp_off", stat_ltp, 0);
`endif
        check("stat_ltd_zero", stat_ltd, 0);
        idle(80, 1'b1);

        for (int t = 0; t < 3000; t++) begin
            logic [N-1:0] p;
            for (int i = 0; i < N; i++) p[i] = ($urandom % 12) == 0;
            if (t == 1500) do_reset();
            cycle(p, ($urandom % 10) == 0, ($urandom % 10) != 0, ($urandom % 10) < 7);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/stdp_update_scheduler.md
Name: stdp_update_scheduler

Overview:
Sequences weight updates for the shared STDP engine in the 5-pre / 1-post LIF network. It tracks time since each presynaptic spike and since the last postsynaptic spike, and turns spike pairings inside a window into pending update requests. Potentiation (LTP) follows pre-before-post; depression (LTD) follows post-before-pre. Pending requests go out one at a time to the single STDP weight engine over a valid/ready handshake, using round-robin arbitration across channels.

Parameters:
N_PRE, 5, number of presynaptic channels (2..8)
TW, 8, timer and time-difference width in bits
WINDOW, 64, maximum time difference (cycles) that produces an update; must be < 2^TW-1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
ena  in  1  design enable; low freezes timers and event capture
pre_spike  in  N_PRE  presynaptic spike pulses; bit i = channel i
post_spike  in  1  postsynaptic spike pulse
upd_valid  out  1  update request valid
upd_ready  in  1  STDP engine accepts request
upd_chan  out  3  channel index of request
upd_ltp  out  1  1 = potentiate, 0 = depress
upd_dt  out  TW  spike time difference for request
busy  out  1  any pending request or upd_valid high
overflow  out  1  sticky: a pending request was overwritten before issue
stat_ltp  out  8  issued-LTP count (optional feature)
stat_ltd  out  8  issued-LTD count (optional feature)

Behaviour:
- Reset (async, rst_n low): all outputs 0; pre_t[i] and post_t = 2^TW-1 ("never"); ltp_pend, ltd_pend = 0; rr_ptr = 0; FSM = IDLE. Async reset mid-handshake drops the request with no side effects.
- Timers (ena high): pre_t[i] <= 0 on pre_spike[i], else +1 saturating at 2^TW-1. post_t behaves the same with post_spike. ena low: timers hold.
- LTP capture (ena and post_spike): for each i, the pre-update pre_t[i] <= WINDOW sets ltp_pend[i] and dt_ltp[i] = pre_t[i]. If pre_spike[i] is high in the same cycle, the event is LTP with dt = 0 and LTD is suppressed for that channel.
- LTD capture (ena and pre_spike[i] with post_spike low): pre-update post_t <= WINDOW sets ltd_pend[i] and dt_ltd[i] = post_t.
- Overwrite: a new capture on a bit already pending replaces dt and sets overflow (sticky until reset).
- Arbitration: search channels starting at rr_ptr, ascending with wrap, for the first channel with any pending bit. Within a channel, LTD is served before LTP.
- FSM IDLE: upd_valid = 0. If any bit is pending, register chan/ltp/dt onto the outputs and go to OFFER.
- FSM OFFER: upd_valid = 1. Payload stays stable until upd_ready. On handshake:
  - clear the issued pending bit (a same-cycle new capture on that bit wins and stays set);
  - rr_ptr = (chan+1) mod N_PRE;
  - go to IDLE.
- Throughput: one issue per 2 cycles.
- Latency: spike at edge t gives pending at t+1 and upd_valid at t+2 (ready held high, bus idle).
- ena does not gate issuance; pending requests drain while ena is low.
- busy = |ltp_pend | |ltd_pend | upd_valid.

Optional Feature:
- Macro: STDP_SCHED_STATS_EN.
- Defined: stat_ltp and stat_ltd are 8-bit saturating counters (hold at 255). Each increments on a handshake with upd_ltp = 1 and upd_ltp = 0 respectively, and resets to 0.
- Not defined: the counters are not built and both ports are tied to 0.

Test Plan:
- Reset, then post_spike with no prior pre -> no upd_valid; busy = 0; overflow = 0.
- pre_spike[2] at cycle 0, post_spike at cycle 10 (ready = 1) -> one request: chan = 2, ltp = 1, dt = 10; upd_valid rises 2 cycles after post.
- post_spike at cycle 0, pre_spike[4] at cycle 5 -> chan = 4, ltp = 0, dt = 5. Same setup with pre at cycle 70 (> WINDOW) -> no request.
- Pre spikes on channels 0, 1, 3 at cycle 0, post at cycle 3, upd_ready held low 20 cycles then high -> payload stable while stalled; issues in order chan 0, 1, 3, each dt = 3.
- Simultaneous pre_spike[1] and post_spike -> single LTP on chan 1, dt = 0, no LTD. A second post while chan-1 LTP is still pending (ready low) -> overflow = 1, dt updated.
- STDP_SCHED_STATS_EN defined: 300 LTP handshakes -> stat_ltp = 255, stat_ltd = 0. Macro undefined -> both read 0.
